// File: rtl/tcp_tx_flag_sched_if.sv
// Shared types and the request/update interface of the TCP TX flag scheduler.
// Flag index order everywhere: rt, ack, data.
package tcp_tx_flag_sched_pkg;
  parameter int unsigned FLOWID_W  = 3;
  parameter int unsigned NUM_FLOWS = 1 << FLOWID_W;
  parameter int unsigned TS_W      = 8;

  typedef enum logic [1:0] {
    CmdNop   = 2'd0,
    CmdSet   = 2'd1,
    CmdClear = 2'd2
  } sched_cmd_e;

  typedef struct packed {
    sched_cmd_e            cmd;
    logic [TS_W-1:0]       timestamp;
  } flag_cmd_t;

  typedef struct packed {
    logic [FLOWID_W-1:0]   flowid;
    flag_cmd_t             rt;
    flag_cmd_t             ack;
    flag_cmd_t             data;
  } sched_cmd_struct;

  typedef struct packed {
    logic                  flag;
    logic [TS_W-1:0]       timestamp;
  } flag_snap_t;

  typedef struct packed {
    logic [FLOWID_W-1:0]   flowid;
    flag_snap_t            rt;
    flag_snap_t            ack;
    flag_snap_t            data;
  } sched_data_struct;
endpackage

interface tcp_tx_flag_sched_if;
  import tcp_tx_flag_sched_pkg::*;

  logic                rx_sched_ack_set_val;
  logic [FLOWID_W-1:0] rx_sched_ack_set_flowid;
  logic                app_sched_data_set_val;
  logic [FLOWID_W-1:0] app_sched_data_set_flowid;
  logic                timer_sched_rt_set_val;
  logic [FLOWID_W-1:0] timer_sched_rt_set_flowid;
  logic                tx_sched_update_val;
  sched_cmd_struct     tx_sched_update_cmd;
  logic                sched_tx_req_val;
  logic                sched_tx_req_rdy;
  sched_data_struct    sched_tx_req_data;
  logic                sched_idle;

  modport master (
    output rx_sched_ack_set_val, rx_sched_ack_set_flowid,
    output app_sched_data_set_val, app_sched_data_set_flowid,
    output timer_sched_rt_set_val, timer_sched_rt_set_flowid,
    output tx_sched_update_val, tx_sched_update_cmd,
    output sched_tx_req_rdy,
    input  sched_tx_req_val, sched_tx_req_data, sched_idle
  );

  modport slave (
    input  rx_sched_ack_set_val, rx_sched_ack_set_flowid,
    input  app_sched_data_set_val, app_sched_data_set_flowid,
    input  timer_sched_rt_set_val, timer_sched_rt_set_flowid,
    input  tx_sched_update_val, tx_sched_update_cmd,
    input  sched_tx_req_rdy,
    output sched_tx_req_val, sched_tx_req_data, sched_idle
  );
endinterface

// File: rtl/tcp_tx_flag_sched.sv
// Per-flow TX work scheduler: timestamped pending flags, round-robin issue over val/rdy,
// and timestamp-guarded clears so a SET racing with processing is never lost.
module tcp_tx_flag_sched
  import tcp_tx_flag_sched_pkg::*;
(
  input logic               clk,
  input logic               rst,
  tcp_tx_flag_sched_if.slave bus_io
);
  localparam int unsigned NumFlags = 3;
  localparam int unsigned FlagRt   = 0;
  localparam int unsigned FlagAck  = 1;
  localparam int unsigned FlagData = 2;

  logic [NumFlags-1:0][NUM_FLOWS-1:0]           flag_q, flag_d;
  logic [NumFlags-1:0][NUM_FLOWS-1:0][TS_W-1:0] ts_q, ts_d;
  logic [NUM_FLOWS-1:0]                         in_flight_q, in_flight_d;
  logic [FLOWID_W-1:0]                          rr_ptr_q, rr_ptr_d;
  logic                                         req_val_q, req_val_d;
  sched_data_struct                             req_data_q, req_data_d;

  logic [NumFlags-1:0][NUM_FLOWS-1:0] set_hit, clr_hit;
  flag_cmd_t [NumFlags-1:0]           upd_cmd;
  logic [FLOWID_W-1:0]                upd_fid;
  logic [NUM_FLOWS-1:0]               eligible;
  logic [FLOWID_W-1:0]                sel, idx;
  logic                               reg_free, load;

  // Decode all SET/CLEAR events for this cycle; a SET on a flag overrides a clear.
  always_comb begin
    set_hit          = '0;
    clr_hit          = '0;
    upd_fid          = bus_io.tx_sched_update_cmd.flowid;
    upd_cmd[FlagRt]   = bus_io.tx_sched_update_cmd.rt;
    upd_cmd[FlagAck]  = bus_io.tx_sched_update_cmd.ack;
    upd_cmd[FlagData] = bus_io.tx_sched_update_cmd.data;
    if (bus_io.tx_sched_update_val) begin
      for (int k = 0; k < int'(NumFlags); k++) begin
        case (upd_cmd[k].cmd)
          CmdSet:   set_hit[k][upd_fid] = 1'b1;
          CmdClear: clr_hit[k][upd_fid] = (upd_cmd[k].timestamp == ts_q[k][upd_fid]);
          default:  ;
        endcase
      end
    end
    if (bus_io.rx_sched_ack_set_val) set_hit[FlagAck][bus_io.rx_sched_ack_set_flowid] = 1'b1;
    if (bus_io.app_sched_data_set_val) begin
      set_hit[FlagData][bus_io.app_sched_data_set_flowid] = 1'b1;
    end
    if (bus_io.timer_sched_rt_set_val) set_hit[FlagRt][bus_io.timer_sched_rt_set_flowid] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < int'(NumFlags); k++) begin
      for (int f = 0; f < int'(NUM_FLOWS); f++) begin
        flag_d[k][f] = set_hit[k][f] | (flag_q[k][f] & ~clr_hit[k][f]);
        ts_d[k][f]   = set_hit[k][f] ? ts_q[k][f] + TS_W'(1) : ts_q[k][f];
      end
    end
  end

  // Scan downwards so the closest eligible flow after rr_ptr wins; i == NUM_FLOWS is rr_ptr.
  always_comb begin
    eligible = (flag_q[FlagRt] | flag_q[FlagAck] | flag_q[FlagData]) & ~in_flight_q;
    sel      = rr_ptr_q;
    idx      = '0;
    for (int i = int'(NUM_FLOWS); i >= 1; i--) begin
      idx = rr_ptr_q + FLOWID_W'(i);
      if (eligible[idx]) sel = idx;
    end
  end

  always_comb begin
    reg_free    = ~req_val_q | bus_io.sched_tx_req_rdy;
    load        = reg_free & (|eligible);
    in_flight_d = in_flight_q;
    rr_ptr_d    = rr_ptr_q;
    req_val_d   = req_val_q;
    req_data_d  = req_data_q;
    if (bus_io.tx_sched_update_val) in_flight_d[upd_fid] = 1'b0;
    if (load) begin
      req_data_d.flowid = sel;
      req_data_d.rt     = {flag_q[FlagRt][sel], ts_q[FlagRt][sel]};
      req_data_d.ack    = {flag_q[FlagAck][sel], ts_q[FlagAck][sel]};
      req_data_d.data   = {flag_q[FlagData][sel], ts_q[FlagData][sel]};
      req_val_d         = 1'b1;
      in_flight_d[sel]  = 1'b1;
      rr_ptr_d          = sel;
    end else if (reg_free) begin
      req_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q      <= '0;
      ts_q        <= '0;
      in_flight_q <= '0;
      rr_ptr_q    <= FLOWID_W'(NUM_FLOWS - 1);
      req_val_q   <= 1'b0;
      req_data_q  <= '0;
    end else begin
      flag_q      <= flag_d;
      ts_q        <= ts_d;
      in_flight_q <= in_flight_d;
      rr_ptr_q    <= rr_ptr_d;
      req_val_q   <= req_val_d;
      req_data_q  <= req_data_d;
    end
  end

  assign bus_io.sched_tx_req_val  = req_val_q;
  assign bus_io.sched_tx_req_data = req_data_q;
  assign bus_io.sched_idle        = ~(|flag_q) & ~(|in_flight_q) & ~req_val_q;
endmodule

// File: doc/tcp_tx_flag_sched.md
Name: tcp_tx_flag_sched

Overview:
Per-flow TX work scheduler feeding the TCP TX protocol-calc datapath. It holds three pending flags per flow: retransmit, ack-pending and data-pending. Each flag carries a generation timestamp. The block round-robin selects flows with work and issues sched_data_struct requests over a val/rdy handshake. It applies the datapath's sched_cmd_struct update, which clears a flag only if the timestamps match, so that a SET arriving during processing is never lost.

Parameters:
NUM_FLOWS, 8, number of flows tracked (= 2**FLOWID_W)
FLOWID_W, 3, flow id width
TS_W, 8, per-flag generation timestamp width (sched_data_struct timestamp field width)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rx_sched_ack_set_val  in  1  set ack-pending flag of rx_sched_ack_set_flowid
rx_sched_ack_set_flowid  in  FLOWID_W  target flow
app_sched_data_set_val  in  1  set data-pending flag
app_sched_data_set_flowid  in  FLOWID_W  target flow
timer_sched_rt_set_val  in  1  set retransmit flag
timer_sched_rt_set_flowid  in  FLOWID_W  target flow
tx_sched_update_val  in  1  update command valid (always accepted)
tx_sched_update_cmd  in  sched_cmd_struct  flowid plus {cmd,timestamp} for rt/ack/data
sched_tx_req_val  out  1  request valid
sched_tx_req_rdy  in  1  datapath accepts request
sched_tx_req_data  out  sched_data_struct  flowid plus {flag,timestamp} for rt/ack/data
sched_idle  out  1  no flags set and nothing in flight

Behaviour:
- Reset (sync, rst=1 at an edge): all flags 0, all timestamps 0, in_flight 0, rr_ptr=NUM_FLOWS-1, sched_tx_req_val=0, sched_tx_req_data=0, sched_idle=1. A reset mid-handshake drops the request; the datapath must treat any subsequent update as stale (flags are 0).
- State per flow f and per flag k: flag[f][k], ts[f][k] (TS_W), plus in_flight[f].
- SET (set port, or update cmd==SET): flag<=1; ts<=ts+1, mod 2**TS_W (wrap 255->0).
- CLEAR (update cmd): if cmd.timestamp==ts[f][k] then flag<=0, else no change. ts is never changed by CLEAR.
- NOP: no change.
- Set ports and the update port act on independent flags. Same flag, same cycle, SET and matching CLEAR: SET wins (flag=1, ts+1).
- Any tx_sched_update_val clears in_flight[cmd.flowid], whatever the cmd values.
- eligible[f] = (rt|ack|data)[f] & ~in_flight[f].
- Selection: combinational over registered state; first eligible flow scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_FLOWS.
- Output register loads when (!sched_tx_req_val | sched_tx_req_rdy) and an eligible flow exists. On load:
  - data = {flowid, snapshot of all three flag/ts pairs};
  - val<=1;
  - in_flight[sel]<=1;
  - rr_ptr<=sel.
- If the register is free and no flow is eligible: val<=0 (or val drops after rdy).
- Back-to-back issue (one per cycle) is allowed while rdy=1.
- Outputs are stable while val=1 and rdy=0. Snapshot flags/timestamps do not update if a SET occurs while waiting.
- Latency: a set sampled at edge k (flow idle, register free) gives val=1 after edge k+1.
- An in-flight flow is never reissued until its update arrives. A set on an in-flight flow is recorded and reissued after the update, because its ts mismatches the CLEAR.
- Update for a flow not in flight: flags updated normally; no error.
- sched_idle = no flag set anywhere & no in_flight & !sched_tx_req_val (registered-state combinational).

Test Plan:
- Reset, then app set flow 2 at edge 0 -> val=1 after edge 1, data.flowid=2, data_pend{1,ts=1}, rt/ack flags 0; with rdy=1 the next cycle has val=0.
- Ack sets on flows 1, 5, 6 at the same edge, rdy=1 -> issues in order 1, 5, 6 on consecutive cycles; rr_ptr=6, sched_idle=0 until the updates arrive.
- Flow 3 ack set (ts=1) and issued; another ack set before the update (ts=2); update CLEAR ts=1 -> flag stays 1 and flow 3 reissues with ack ts=2; update CLEAR ts=2 -> flag 0, sched_idle=1.
- rdy held 0 for 5 cycles with flow 4 issued, rt set on flow 4 meanwhile -> data stays bit-identical (rt flag 0 in snapshot); flow 4 not reissued until the update.
- 256 SETs to flow 0 data flag -> ts wraps to 0; CLEAR ts=0 clears it.
- Same edge: update CLEAR ts=1 and app set on flow 7 data (ts=1) -> flag 1, ts=2; flow 7 reissued next cycle.
- rst asserted while val=1 and rdy=0 -> next cycle val=0, all flags 0, sched_idle=1.
